tile_scheduler: RTL and testbench

TILE_SCHEDULER -- requirements
Module: tile_scheduler

---
 rtl/tile_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_tile_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_scheduler.sv
// tile_scheduler: sequences a systolic array over (head, row, col) tiles.
//   For each tile it pulses arr_start and waits for arr_dout_done. While a
//   tile runs, it translates the array's local read/write indices into SRAM
//   addresses.
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start, abort      job request pulse / cancel the running job
//   k_param, row_shape, col_shape, num_heads
//                     job shape, latched when a job is accepted
//   in_base, w_base, w_head_stride, out_base, out_head_stride
//                     address bases and per-head strides, latched at accept
//   arr_start         one-cycle launch pulse to the array
//   arr_raddr, arr_waddr, arr_wen_n, arr_dout_done
//                     local indices, write strobe and completion from array
//   raddr_input, raddr_w, waddr_out, wen_out_n
//                     translated SRAM addresses and output write strobe
//   busy, done, err   status; done and err are one-cycle pulses
//   cur_row, cur_col, cur_head
//                     tile counters
//   fsm_state         debug view of the controller state
// Handshake: arr_start is a single-cycle pulse. arr_dout_done is only
//   sampled in WAIT; a pulse in any other state is dropped.
module tile_scheduler #(
  parameter int N  = 8,
  parameter int AW = 13,
  parameter int DW = 8,
  parameter int HW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] k_param,
  input  logic [DW-1:0] row_shape,
  input  logic [DW-1:0] col_shape,
  input  logic [HW-1:0] num_heads,
  input  logic [AW-1:0] in_base,
  input  logic [AW-1:0] w_base,
  input  logic [AW-1:0] w_head_stride,
  input  logic [AW-1:0] out_base,
  input  logic [AW-1:0] out_head_stride,
  output logic          arr_start,
  input  logic [AW-1:0] arr_raddr,
  input  logic [AW-1:0] arr_waddr,
  input  logic          arr_wen_n,
  input  logic          arr_dout_done,
  output logic [AW-1:0] raddr_input,
  output logic [AW-1:0] raddr_w,
  output logic [AW-1:0] waddr_out,
  output logic          wen_out_n,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] cur_row,
  output logic [DW-1:0] cur_col,
  output logic [HW-1:0] cur_head,
  output logic [2:0]    fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_NEXT   = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  localparam logic [AW-1:0] N_A = AW'(N);

  state_t state, state_nx;

  logic [DW-1:0] k_q, rs_q, cs_q;
  logic [HW-1:0] nh_q;
  logic [AW-1:0] in_base_q, w_base_q, w_stride_q, out_base_q, out_stride_q;
  logic          err_q;

  logic cfg_ok, idle_start, accept, kill;
  logic last_col, last_row, last_head, last_tile;

  assign cfg_ok     = (|k_param) && (|row_shape) && (|col_shape) && (|num_heads);
  // Abort in IDLE suppresses both job start and the err pulse.
  assign idle_start = (state == S_IDLE) && start && !abort;
  assign accept     = idle_start && cfg_ok;
  assign kill       = abort && (state != S_IDLE);

  assign last_col  = (cur_col  == cs_q - DW'(1));
  assign last_row  = (cur_row  == rs_q - DW'(1));
  assign last_head = (cur_head == nh_q - HW'(1));
  assign last_tile = last_col && last_row && last_head;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; abort overrides every transition out of a busy state.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (accept) state_nx = S_LAUNCH;
      S_LAUNCH: state_nx = S_WAIT;
      S_WAIT:   if (arr_dout_done) state_nx = S_NEXT;
      S_NEXT:   state_nx = last_tile ? S_FINISH : S_LAUNCH;
      S_FINISH: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
    if (kill) state_nx = S_IDLE;
  end

  // Outputs decoded from state
  always_comb begin
    arr_start = (state == S_LAUNCH);
    busy      = (state != S_IDLE);
    done      = (state == S_FINISH);
    err       = err_q;
    wen_out_n = (state == S_WAIT) ? arr_wen_n : 1'b1;
    fsm_state = state;
  end

  // Configuration latch, tile counters and the registered err pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q          <= '0;
      rs_q         <= '0;
      cs_q         <= '0;
      nh_q         <= '0;
      in_base_q    <= '0;
      w_base_q     <= '0;
      w_stride_q   <= '0;
      out_base_q   <= '0;
      out_stride_q <= '0;
      cur_row      <= '0;
      cur_col      <= '0;
      cur_head     <= '0;
      err_q        <= 1'b0;
    end else begin
      err_q <= idle_start && !cfg_ok;
      if (accept) begin
        k_q          <= k_param;
        rs_q         <= row_shape;
        cs_q         <= col_shape;
        nh_q         <= num_heads;
        in_base_q    <= in_base;
        w_base_q     <= w_base;
        w_stride_q   <= w_head_stride;
        out_base_q   <= out_base;
        out_stride_q <= out_head_stride;
        cur_row      <= '0;
        cur_col      <= '0;
        cur_head     <= '0;
      end else if (kill || state == S_FINISH) begin
        cur_row  <= '0;
        cur_col  <= '0;
        cur_head <= '0;
      end else if (state == S_NEXT) begin
        // col is the fastest counter, then row, then head
        if (last_col) begin
          cur_col <= '0;
          if (last_row) begin
            cur_row  <= '0;
            cur_head <= last_head ? '0 : cur_head + HW'(1);
          end else begin
            cur_row <= cur_row + DW'(1);
          end
        end else begin
          cur_col <= cur_col + DW'(1);
        end
      end
    end
  end

  // Address translation. All terms are zero-extended or truncated to AW bits,
  // so every sum wraps modulo 2^AW.
  logic [AW-1:0] row_a, col_a, head_a, k_a, cs_a;

  always_comb begin
    row_a       = AW'(cur_row);
    col_a       = AW'(cur_col);
    head_a      = AW'(cur_head);
    k_a         = AW'(k_q);
    cs_a        = AW'(cs_q);
    raddr_input = in_base_q + row_a * k_a + arr_raddr;
    raddr_w     = w_base_q + head_a * w_stride_q + col_a * k_a + arr_raddr;
    waddr_out   = out_base_q + head_a * out_stride_q
                + (row_a * cs_a + col_a) * N_A + arr_waddr;
  end

endmodule

// File: tb/tb_tile_scheduler.sv
// tb_tile_scheduler: directed and randomized checks of tile_scheduler.
//   The expected tile order comes from nested loops over (head, row, col).
//   The expected addresses come from integer formulas reduced modulo 2^AW.
module tb_tile_scheduler;
  localparam int N  = 8;
  localparam int AW = 13;
  localparam int DW = 8;
  localparam int HW = 2;
  localparam int M  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, abort;
  logic [DW-1:0] k_param, row_shape, col_shape;
  logic [HW-1:0] num_heads;
  logic [AW-1:0] in_base, w_base, w_head_stride, out_base, out_head_stride;
  logic          arr_start;
  logic [AW-1:0] arr_raddr, arr_waddr;
  logic          arr_wen_n, arr_dout_done;
  logic [AW-1:0] raddr_input, raddr_w, waddr_out;
  logic          wen_out_n, busy, done, err;
  logic [DW-1:0] cur_row, cur_col;
  logic [HW-1:0] cur_head;
  logic [2:0]    fsm_state;

  tile_scheduler #(.N(N), .AW(AW), .DW(DW), .HW(HW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .k_param(k_param), .row_shape(row_shape), .col_shape(col_shape),
    .num_heads(num_heads),
    .in_base(in_base), .w_base(w_base), .w_head_stride(w_head_stride),
    .out_base(out_base), .out_head_stride(out_head_stride),
    .arr_start(arr_start), .arr_raddr(arr_raddr), .arr_waddr(arr_waddr),
    .arr_wen_n(arr_wen_n), .arr_dout_done(arr_dout_done),
    .raddr_input(raddr_input), .raddr_w(raddr_w), .waddr_out(waddr_out),
    .wen_out_n(wen_out_n), .busy(busy), .done(done), .err(err),
    .cur_row(cur_row), .cur_col(cur_col), .cur_head(cur_head),
    .fsm_state(fsm_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;

  // Job configuration used by the reference model
  int k, rs, cs, nh, ib, wb, ws, ob, os;

  // Optional directed probe: on the first WAIT cycle of tile (p_h,p_r,p_c)
  // drive arr_raddr=p_ra and compare one address against a constant.
  int p_sig = 0, p_h = 0, p_r = 0, p_c = 0, p_ra = 0, p_exp = 0, p_hits = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_ri(int r, int ra);
    return (ib + r * k + ra) % M;
  endfunction

  function automatic int m_rw(int h, int c, int ra);
    return (wb + h * ws + c * k + ra) % M;
  endfunction

  function automatic int m_wo(int h, int r, int c, int wa);
    return (ob + h * os + (r * cs + c) * N + wa) % M;
  endfunction

  task automatic apply_cfg();
    k_param         = DW'(k);
    row_shape       = DW'(rs);
    col_shape       = DW'(cs);
    num_heads       = HW'(nh);
    in_base         = AW'(ib);
    w_base          = AW'(wb);
    w_head_stride   = AW'(ws);
    out_base        = AW'(ob);
    out_head_stride = AW'(os);
  endtask

  task automatic rand_cfg();
    k  = $urandom_range(1, 255);
    rs = $urandom_range(1, 3);
    cs = $urandom_range(1, 3);
    nh = $urandom_range(1, 3);
    ib = $urandom_range(0, M - 1);
    wb = $urandom_range(0, M - 1);
    ws = $urandom_range(0, M - 1);
    ob = $urandom_range(0, M - 1);
    os = $urandom_range(0, M - 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_arr_start"}, 32'(arr_start), 0);
    chk({tag, "_wen_out_n"}, 32'(wen_out_n), 1);
    chk({tag, "_cur"}, {8'(cur_head), 8'(cur_row), 8'(cur_col)}, 0);
  endtask

  // Array model plus scoreboard for one job. The array answers
  // arr_dout_done after dly+1 WAIT cycles. abort_tile >= 0 aborts together
  // with arr_dout_done on that tile (0-based).
  task automatic run_job(input int dly, input int abort_tile);
    int eh[$], er[$], ec[$];
    int ch = 0, cr = 0, cc = 0, cnt = 0, n_starts = 0, n_done = 0, ntiles;
    bit in_wait = 0, first = 0, finished = 0, aborted = 0, probe_now;
    for (int h = 0; h < nh; h++)
      for (int r = 0; r < rs; r++)
        for (int c = 0; c < cs; c++) begin
          eh.push_back(h); er.push_back(r); ec.push_back(c);
        end
    ntiles = eh.size();
    p_hits = 0;
    apply_cfg();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    for (int cyc = 0; cyc < 3000 && !finished && !aborted; cyc++) begin
      start = 1'b0;
      arr_dout_done = 1'b0;
      if (arr_start) begin
        n_starts++;
        if (eh.size() == 0) begin
          chk("extra_arr_start", 32'(n_starts), 32'(ntiles));
        end else begin
          ch = eh.pop_front(); cr = er.pop_front(); cc = ec.pop_front();
          chk("tile_head", 32'(cur_head), 32'(ch));
          chk("tile_row", 32'(cur_row), 32'(cr));
          chk("tile_col", 32'(cur_col), 32'(cc));
        end
        chk("wen_launch", 32'(wen_out_n), 1);
        // A completion pulse during LAUNCH must be dropped.
        arr_dout_done = 1'($urandom_range(0, 1));
        in_wait = 1'b1; cnt = dly; first = 1'b1;
      end else if (done) begin
        n_done++;
        finished = 1'b1;
      end else if (in_wait) begin
        arr_raddr = AW'($urandom_range(0, M - 1));
        arr_waddr = AW'($urandom_range(0, M - 1));
        arr_wen_n = 1'($urandom_range(0, 1));
        probe_now = (p_sig != 0) && first && ch == p_h && cr == p_r && cc == p_c;
        if (probe_now) arr_raddr = AW'(p_ra);
        // A mid-job start with scrambled config must be ignored.
        if ($urandom_range(0, 3) == 0) begin
          start = 1'b1;
          k_param = DW'($urandom); row_shape = DW'($urandom);
          col_shape = DW'($urandom); num_heads = HW'($urandom);
          in_base = AW'($urandom); w_base = AW'($urandom);
          out_base = AW'($urandom);
        end
        #1;
        chk("raddr_input", 32'(raddr_input), 32'(m_ri(cr, int'(arr_raddr))));
        chk("raddr_w", 32'(raddr_w), 32'(m_rw(ch, cc, int'(arr_raddr))));
        chk("waddr_out", 32'(waddr_out), 32'(m_wo(ch, cr, cc, int'(arr_waddr))));
        chk("wen_wait", 32'(wen_out_n), 32'(arr_wen_n));
        if (probe_now) begin
          p_hits++;
          chk("probe_addr", (p_sig == 1) ? 32'(raddr_input) : 32'(raddr_w), 32'(p_exp));
        end
        first = 1'b0;
        if (cnt == 0) begin
          arr_dout_done = 1'b1;
          in_wait = 1'b0;
          if (n_starts == abort_tile + 1) begin
            abort = 1'b1;
            aborted = 1'b1;
          end
        end else begin
          cnt--;
        end
      end
      tick();
    end
    start = 1'b0;
    arr_dout_done = 1'b0;
    if (aborted) begin
      chk("abort_busy", 32'(busy), 0);
      chk("abort_state_idle", 32'(fsm_state), 0);
      abort = 1'b0;
      for (int i = 0; i < 6; i++) begin
        chk("abort_no_done", 32'(done), 0);
        chk("abort_no_arr_start", 32'(arr_start), 0);
        tick();
      end
      check_idle_outputs("after_abort");
      chk("abort_start_count", 32'(n_starts), 32'(abort_tile + 1));
    end else if (!finished) begin
      chk("timeout_job", 0, 1);
    end else begin
      for (int i = 0; i < 4; i++) begin
        chk("single_done", 32'(done), 0);
        tick();
      end
      check_idle_outputs("after_job");
      chk("done_count", 32'(n_done), 1);
      chk("start_count", 32'(n_starts), 32'(ntiles));
      chk("tiles_left", 32'(eh.size()), 0);
    end
    if (p_sig != 0) chk("probe_hit", 32'(p_hits), 1);
    p_sig = 0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    arr_raddr = '0; arr_waddr = '0; arr_wen_n = 1'b1; arr_dout_done = 1'b0;
    k = 1; rs = 1; cs = 1; nh = 1; ib = 0; wb = 0; ws = 0; ob = 0; os = 0;
    apply_cfg();

    // Outputs while reset is held
    tick();
    start = 1'b1;
    tick();
    check_idle_outputs("reset");
    chk("reset_err", 32'(err), 0);
    chk("reset_state", 32'(fsm_state), 0);
    start = 1'b0;
    rst = 1'b0;
    tick();

    // 2x3 tiles, one head, completion about 10 cycles after arr_start
    k = 8; rs = 2; cs = 3; nh = 1;
    ib = 16'h0040; wb = 16'h0200; ws = 16'h0010; ob = 16'h0800; os = 16'h0100;
    run_job(9, -1);

    // Zero col_shape: err pulse only
    cs = 0;
    apply_cfg();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_err_pulse", 32'(err), 1);
    chk("zero_busy", 32'(busy), 0);
    tick();
    chk("zero_err_cleared", 32'(err), 0);
    for (int i = 0; i < 4; i++) begin
      chk("zero_idle", {30'(0), arr_start, done}, 0);
      tick();
    end
    chk("zero_busy_end", 32'(busy), 0);

    // Abort beats start in IDLE: nothing starts, no err
    k = 5; rs = 1; cs = 1; nh = 1;
    apply_cfg();
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abort_vs_start_busy", 32'(busy), 0);
    chk("abort_vs_start_err", 32'(err), 0);

    // Weight-address directed probe: head 2, col 1, arr_raddr 5
    k = 8; rs = 1; cs = 2; nh = 3;
    ib = 0; wb = 16'h0100; ws = 16'h0040; ob = 0; os = 16'h0020;
    p_sig = 2; p_h = 2; p_r = 0; p_c = 1; p_ra = 5; p_exp = 16'h018D;
    run_job(2, -1);

    // Input-address wrap-around probe: row 1, in_base 0x1FF0, k 0x20
    k = 16'h20; rs = 2; cs = 1; nh = 1;
    ib = 16'h1FF0; wb = 16'h1000; ws = 0; ob = 16'h1FFC; os = 0;
    p_sig = 1; p_h = 0; p_r = 1; p_c = 0; p_ra = 0; p_exp = 16'h0010;
    run_job(1, -1);

    // Abort together with arr_dout_done on the second tile
    k = 8; rs = 2; cs = 3; nh = 1;
    ib = 16'h0100; wb = 16'h0300; ws = 0; ob = 16'h0500; os = 0;
    run_job(3, 1);

    // Reset during WAIT, then a fresh job starting at tile (0,0,0)
    k = 12; rs = 2; cs = 2; nh = 2;
    ib = 16'h0010; wb = 16'h0400; ws = 16'h0080; ob = 16'h0A00; os = 16'h0040;
    apply_cfg();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20 && !arr_start; i++) tick();
    chk("rst_test_launch", 32'(arr_start), 1);
    tick();
    tick();
    tick();
    chk("rst_test_in_wait_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check_idle_outputs("mid_rst");
    chk("mid_rst_err", 32'(err), 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("post_rst_no_done", 32'(done), 0);
      tick();
    end
    run_job(2, -1);

    // Randomized jobs
    for (int j = 0; j < 4; j++) begin
      rand_cfg();
      run_job($urandom_range(0, 4), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
